pwconv_mac_driver: RTL and testbench
====================================

Name: pwconv_mac_driver

Overview:
- Initiator side of the pointwise-conv MAC array interface: accepts a stream of MAC_IN_NUM-wide input pixel vectors and drives the MAC data port, the per-beat weight index and the accumulator reset strobes.
- Produces the output-valid strobe that marks when each group's clipped result is present on the MAC output bus.
- Sits between the input line buffer and configurable MAC array; the output collector uses out_valid_o to capture MAC results.

Parameters:
- MAC_IN_NUM, 9, input channels per beat.
- MAC_OUT_NUM, 18, MAC output channels (width of adder_rst_o).
- DATA_WIDTH, 8, bits per input element.
- ACC_LAT, 12, cycles from a beat driven on MAC_data_o to its product reaching the MAC accumulator input.
- OUT_LAT, 16, cycles from the last beat of a group driven on MAC_data_o to that group's clipped result being valid on the MAC output bus. Must be greater than ACC_LAT.

Ports:
- clk, in, 1, clock.
- rstn, in, 1, asynchronous active-low reset.
- start_i, in, 1, one-cycle start pulse; ignored unless the FSM is in IDLE.
- cfg_accumulate_num_i, in, 8, beats per group N; latched at start. A value of 0 is treated as 1.
- cfg_group_num_i, in, 16, groups per run G; latched at start.
- s_data_i, in, MAC_IN_NUM*DATA_WIDTH, input pixel vector.
- s_valid_i, in, 1, input beat valid.
- s_ready_o, out, 1, input ready.
- MAC_data_o, out, MAC_IN_NUM*DATA_WIDTH, data to the MAC.
- MAC_data_valid_o, out, 1, beat valid to the MAC.
- weight_sel_o, out, 8, index of the current beat within its group (0..N-1).
- adder_rst_o, out, MAC_OUT_NUM, accumulator load strobe; all bits identical.
- out_valid_o, out, 1, one-cycle strobe: the group result is valid on the MAC output.
- busy_o, out, 1, high in RUN and DRAIN.
- done_o, out, 1, one-cycle pulse at the end of a run.

Behaviour:
- Reset values: all outputs 0. FSM in IDLE. Counters and delay lines are cleared.
- FSM states:
  - IDLE: on start_i, latch N and G. Go to RUN if G>0. If G==0, go to DONE.
  - RUN: s_ready_o=1. A beat is accepted when s_valid_i && s_ready_o. After the last beat of group G-1 is accepted, go to DRAIN.
  - DRAIN: s_ready_o=0. Wait until both delay lines are empty, then go to DONE.
  - DONE: done_o=1 for one cycle, then go to IDLE.
- Beat path (registered, 1-cycle latency):
  - On an accepted beat, MAC_data_o=s_data_i, MAC_data_valid_o=1 and weight_sel_o=beat counter, all on the next cycle.
  - On a non-accepted cycle, MAC_data_o is forced to all-zero and MAC_data_valid_o=0. This guarantees that bubbles add zero to the accumulator. weight_sel_o holds its value.
- Counters:
  - Beat counter counts 0..N-1 and wraps to 0 on the Nth accepted beat.
  - Group counter increments on each wrap.
  - Both counters advance only on accepted beats.
- first flag = accepted beat with beat counter 0.
- last flag = accepted beat with beat counter N-1. When N=1, first and last are the same beat.
- adder_rst_o: all bits assert for one cycle exactly ACC_LAT cycles after the first beat appears on MAC_data_o. Implemented as an ACC_LAT-deep shift register.
- out_valid_o: asserts for one cycle exactly OUT_LAT cycles after the last beat appears on MAC_data_o. Implemented as an OUT_LAT-deep shift register.
- Back-to-back groups with no bubbles are legal. A group's final sum is held in the accumulator for one cycle before the next adder_rst; this is sufficient because the MAC scale/clip pipeline captures it.
- start_i while busy is ignored. Config inputs may change freely after start.
- rstn asserted mid-run aborts immediately: all outputs drop to 0, in-flight strobes are discarded, and no done_o is produced.
- Delay lines keep shifting in every state.

Test Plan:
- N=3, G=2, s_valid_i held high:
  - MAC_data_valid_o is high for 6 consecutive cycles starting 1 cycle after the first accept; weight_sel_o reads 0,1,2,0,1,2.
  - adder_rst_o=all-ones at data cycles 0+12 and 3+12.
  - out_valid_o fires at data cycles 2+16 and 5+16.
  - done_o fires after the last out_valid_o; busy_o is low afterwards.
- N=4, G=1, s_valid_i toggled 1,0,1,0,...: MAC_data_o=0 on each bubble cycle; weight_sel_o=0,1,2,3 on the valid beats; exactly one adder_rst_o pulse and one out_valid_o pulse.
- cfg_accumulate_num_i=0, G=3: behaves as N=1; adder_rst_o and out_valid_o pulse for every beat; 3 out_valid_o pulses in total.
- cfg_group_num_i=0: done_o fires 2 cycles after start_i; there are no MAC_data_valid_o, adder_rst_o or out_valid_o pulses.
- Second start_i during RUN: ignored; the run completes with the original N and G.
- rstn pulsed low mid-group (N=5, G=4, after 7 beats): all outputs go to 0 immediately. After release, the FSM is in IDLE and no stale adder_rst_o or out_valid_o appears. A new run with N=2, G=1 completes normally.

Source files
------------

// File: rtl/pwconv_mac_driver.sv
// Initiator for the pointwise-conv MAC array: registers input beats onto the MAC data port
// and times the accumulator-load and output-valid strobes through fixed delay lines.
module pwconv_mac_driver #(
    parameter int MAC_IN_NUM  = 9,
    parameter int MAC_OUT_NUM = 18,
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_LAT     = 12,
    parameter int OUT_LAT     = 16
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             start_i,
    input  logic [7:0]                       cfg_accumulate_num_i,
    input  logic [15:0]                      cfg_group_num_i,
    input  logic [MAC_IN_NUM*DATA_WIDTH-1:0] s_data_i,
    input  logic                             s_valid_i,
    output logic                             s_ready_o,
    output logic [MAC_IN_NUM*DATA_WIDTH-1:0] MAC_data_o,
    output logic                             MAC_data_valid_o,
    output logic [7:0]                       weight_sel_o,
    output logic [MAC_OUT_NUM-1:0]           adder_rst_o,
    output logic                             out_valid_o,
    output logic                             busy_o,
    output logic                             done_o
);
    localparam int VEC_W = MAC_IN_NUM * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state;
    state_t              state_next;
    logic [7:0]          n_reg;
    logic [15:0]         g_reg;
    logic [7:0]          beat_cnt;
    logic [15:0]         group_cnt;
    logic                accept;
    logic                first_beat;
    logic                last_beat;
    logic                run_end;
    logic                lines_empty;
    logic [VEC_W-1:0]    data_p1;
    logic                vld_p1;
    logic [7:0]          wsel_p1;
    logic                first_p1;
    logic                last_p1;
    logic [ACC_LAT-1:0]  first_sr;
    logic [OUT_LAT-1:0]  last_sr;
    logic                done_r;

    assign accept      = (state == RUN) && s_valid_i;
    assign first_beat  = accept && (beat_cnt == 8'd0);
    assign last_beat   = accept && (beat_cnt == n_reg - 8'd1);
    assign run_end     = last_beat && (group_cnt == g_reg - 16'd1);
    assign lines_empty = !first_p1 && !last_p1 && (first_sr == '0) && (last_sr == '0);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = (cfg_group_num_i == 16'd0) ? DONE : RUN;
            RUN:     if (run_end) state_next = DRAIN;
            DRAIN:   if (lines_empty) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            n_reg     <= 8'd1;
            g_reg     <= 16'd0;
            beat_cnt  <= 8'd0;
            group_cnt <= 16'd0;
            done_r    <= 1'b0;
        end else begin
            state  <= state_next;
            done_r <= (state == DONE);
            if (state == IDLE && start_i) begin
                n_reg     <= (cfg_accumulate_num_i == 8'd0) ? 8'd1 : cfg_accumulate_num_i;
                g_reg     <= cfg_group_num_i;
                beat_cnt  <= 8'd0;
                group_cnt <= 16'd0;
            end else if (accept) begin
                if (last_beat) begin
                    beat_cnt  <= 8'd0;
                    group_cnt <= group_cnt + 16'd1;
                end else begin
                    beat_cnt <= beat_cnt + 8'd1;
                end
            end
        end
    end

    // Stage p1: beat onto the MAC port; bubbles are zeroed so they add nothing to the sum
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_p1  <= '0;
            vld_p1   <= 1'b0;
            wsel_p1  <= 8'd0;
            first_p1 <= 1'b0;
            last_p1  <= 1'b0;
            first_sr <= '0;
            last_sr  <= '0;
        end else begin
            data_p1  <= accept ? s_data_i : '0;
            vld_p1   <= accept;
            if (accept) wsel_p1 <= beat_cnt;
            first_p1 <= first_beat;
            last_p1  <= last_beat;
            first_sr <= {first_sr[ACC_LAT-2:0], first_p1};
            last_sr  <= {last_sr[OUT_LAT-2:0], last_p1};
        end
    end

    assign s_ready_o        = (state == RUN);
    assign busy_o           = (state == RUN) || (state == DRAIN);
    assign done_o           = done_r;
    assign MAC_data_o       = data_p1;
    assign MAC_data_valid_o = vld_p1;
    assign weight_sel_o     = wsel_p1;
    assign adder_rst_o      = {MAC_OUT_NUM{first_sr[ACC_LAT-1]}};
    assign out_valid_o      = last_sr[OUT_LAT-1];

endmodule

// File: tb/tb_pwconv_mac_driver.sv
// Directed bench for pwconv_mac_driver: captures per-cycle strobes into bit masks after each
// run and compares them with hand-derived cycle positions.
module tb_pwconv_mac_driver;
    localparam int MAC_IN_NUM  = 9;
    localparam int MAC_OUT_NUM = 18;
    localparam int DATA_WIDTH  = 8;
    localparam int VEC_W       = MAC_IN_NUM * DATA_WIDTH;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic                   start_i;
    logic [7:0]             cfg_accumulate_num_i;
    logic [15:0]            cfg_group_num_i;
    logic [VEC_W-1:0]       s_data_i;
    logic                   s_valid_i;
    logic                   s_ready_o;
    logic [VEC_W-1:0]       MAC_data_o;
    logic                   MAC_data_valid_o;
    logic [7:0]             weight_sel_o;
    logic [MAC_OUT_NUM-1:0] adder_rst_o;
    logic                   out_valid_o;
    logic                   busy_o;
    logic                   done_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0]      m_vld, m_arst, m_ov, m_done, m_busy;
    logic [VEC_W-1:0] rec_data [0:63];
    logic [7:0]       rec_wsel [0:63];

    pwconv_mac_driver dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .start_i              (start_i),
        .cfg_accumulate_num_i (cfg_accumulate_num_i),
        .cfg_group_num_i      (cfg_group_num_i),
        .s_data_i             (s_data_i),
        .s_valid_i            (s_valid_i),
        .s_ready_o            (s_ready_o),
        .MAC_data_o           (MAC_data_o),
        .MAC_data_valid_o     (MAC_data_valid_o),
        .weight_sel_o         (weight_sel_o),
        .adder_rst_o          (adder_rst_o),
        .out_valid_o          (out_valid_o),
        .busy_o               (busy_o),
        .done_o               (done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VEC_W-1:0] vec(input logic [7:0] b);
        return {MAC_IN_NUM{b}};
    endfunction

    function automatic logic [63:0] bit_at(input int i);
        return 64'd1 << i;
    endfunction

    // mode 0: valid always high; mode 1: valid toggles 1,0,...; mode 2: as 0 plus a second start at k=1
    task automatic run_capture(input logic [7:0] n, input logic [15:0] g, input int mode, input int len);
        logic [7:0] b;
        m_vld = '0; m_arst = '0; m_ov = '0; m_done = '0; m_busy = '0;
        cfg_accumulate_num_i = n;
        cfg_group_num_i      = g;
        start_i   = 1'b1;
        s_valid_i = 1'b0;
        s_data_i  = '0;
        step();
        start_i = 1'b0;
        for (int k = 0; k < len; k++) begin
            b         = 8'(k + 64);
            s_data_i  = vec(b);
            s_valid_i = (mode == 1) ? ~k[0] : 1'b1;
            start_i   = (mode == 2 && k == 1);
            if (mode == 2 && k == 1) begin
                cfg_accumulate_num_i = 8'd5;
                cfg_group_num_i      = 16'd9;
            end
            step();
            m_vld[k+1]    = MAC_data_valid_o;
            m_arst[k+1]   = (adder_rst_o == '1);
            m_ov[k+1]     = out_valid_o;
            m_done[k+1]   = done_o;
            m_busy[k+1]   = busy_o;
            rec_data[k+1] = MAC_data_o;
            rec_wsel[k+1] = weight_sel_o;
        end
        s_valid_i = 1'b0;
        start_i   = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; start_i = 1'b0; s_valid_i = 1'b0; s_data_i = '0;
        cfg_accumulate_num_i = 8'd0; cfg_group_num_i = 16'd0;
        repeat (3) step();
        check("rst_outputs", {MAC_data_valid_o, out_valid_o, busy_o, done_o, s_ready_o, |adder_rst_o}, 6'd0);
        check("rst_data", MAC_data_o, '0);
        check("rst_wsel", weight_sel_o, 8'd0);
        rstn = 1'b1;
        step();

        // N=3, G=2, continuous
        run_capture(8'd3, 16'd2, 0, 40);
        check("t1_vld", m_vld, 64'h7E);
        for (int i = 0; i < 6; i++) check($sformatf("t1_wsel%0d", i), rec_wsel[i+1], 8'(i % 3));
        check("t1_data0", rec_data[1], vec(8'h40));
        check("t1_data5", rec_data[6], vec(8'h45));
        check("t1_data_bubble", rec_data[7], '0);
        check("t1_arst", m_arst, bit_at(13) | bit_at(16));
        check("t1_ov", m_ov, bit_at(19) | bit_at(22));
        check("t1_done", m_done, bit_at(25));
        check("t1_busy", m_busy, (bit_at(24) - 64'd1) & ~64'd1);

        // N=4, G=1, valid toggling
        run_capture(8'd4, 16'd1, 1, 40);
        check("t2_vld", m_vld, bit_at(1) | bit_at(3) | bit_at(5) | bit_at(7));
        for (int i = 0; i < 4; i++) check($sformatf("t2_wsel%0d", i), rec_wsel[2*i+1], 8'(i));
        check("t2_bub2", rec_data[2], '0);
        check("t2_bub4", rec_data[4], '0);
        check("t2_data3", rec_data[3], vec(8'h42));
        check("t2_data7", rec_data[7], vec(8'h46));
        check("t2_arst", m_arst, bit_at(13));
        check("t2_ov", m_ov, bit_at(23));
        check("t2_done", m_done, bit_at(26));

        // N=0 behaves as 1, G=3
        run_capture(8'd0, 16'd3, 0, 40);
        check("t3_vld", m_vld, 64'hE);
        for (int i = 0; i < 3; i++) check($sformatf("t3_wsel%0d", i), rec_wsel[i+1], 8'd0);
        check("t3_arst", m_arst, bit_at(13) | bit_at(14) | bit_at(15));
        check("t3_ov", m_ov, bit_at(17) | bit_at(18) | bit_at(19));
        check("t3_done", m_done, bit_at(22));

        // G=0: straight to DONE
        run_capture(8'd3, 16'd0, 0, 30);
        check("t4_done", m_done, bit_at(1));
        check("t4_quiet", {m_vld, m_arst, m_ov, m_busy}, '0);

        // second start during RUN is ignored
        run_capture(8'd2, 16'd2, 2, 40);
        check("t5_vld", m_vld, 64'h1E);
        for (int i = 0; i < 4; i++) check($sformatf("t5_wsel%0d", i), rec_wsel[i+1], 8'(i % 2));
        check("t5_arst", m_arst, bit_at(13) | bit_at(15));
        check("t5_ov", m_ov, bit_at(18) | bit_at(20));
        check("t5_done", m_done, bit_at(23));

        // reset mid-group: N=5, G=4, after 7 beats
        cfg_accumulate_num_i = 8'd5; cfg_group_num_i = 16'd4;
        start_i = 1'b1; s_valid_i = 1'b0;
        step();
        start_i = 1'b0; s_valid_i = 1'b1; s_data_i = vec(8'h77);
        repeat (7) step();
        check("t6_pre", {busy_o, MAC_data_valid_o, s_ready_o}, 3'b111);
        rstn = 1'b0;
        #1;
        check("t6_rst_ctl", {MAC_data_valid_o, out_valid_o, busy_o, done_o, s_ready_o, |adder_rst_o}, 6'd0);
        check("t6_rst_data", MAC_data_o, '0);
        check("t6_rst_wsel", weight_sel_o, 8'd0);
        step();
        rstn = 1'b1;
        m_vld = '0; m_arst = '0; m_ov = '0; m_done = '0; m_busy = '0;
        for (int k = 0; k < 30; k++) begin
            step();
            m_vld[k]  = MAC_data_valid_o | s_ready_o;
            m_arst[k] = |adder_rst_o;
            m_ov[k]   = out_valid_o;
            m_done[k] = done_o;
            m_busy[k] = busy_o;
        end
        s_valid_i = 1'b0;
        check("t6_stale", {m_vld, m_arst, m_ov, m_done, m_busy}, '0);

        run_capture(8'd2, 16'd1, 0, 30);
        check("t6b_vld", m_vld, 64'h6);
        check("t6b_wsel", {rec_wsel[1], rec_wsel[2]}, 16'h0001);
        check("t6b_arst", m_arst, bit_at(13));
        check("t6b_ov", m_ov, bit_at(18));
        check("t6b_done", m_done, bit_at(21));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
